score_seg_encoder: RTL

SCORE_SEG_ENCODER -- requirements
Module: score_seg_encoder

---
 rtl/score_seg_encoder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/score_seg_encoder.sv
// Binary score to 8-digit active-low seven-segment image. A double-dabble FSM
// converts the clamped score to BCD, then one encode edge loads the display word.
module score_seg_encoder #(
    parameter bit          BLANK_LZ  = 1'b1,
    parameter int unsigned CLAMP_MAX = 99999999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] score,
    output logic [63:0] num,
    output logic        busy,
    output logic        done
);

    localparam logic [26:0] ClampVal = 27'(CLAMP_MAX);
    localparam logic [4:0]  LastIter = 5'd26;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StEnc
    } state_e;

    state_e      state_q;
    logic [26:0] work_q;
    logic [26:0] last_q;
    logic [31:0] bcd_q;
    logic [4:0]  cnt_q;
    logic        pending_q;

    logic [31:0] bcd_adj;
    logic [63:0] num_enc;
    logic        lead;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Scan from the top digit; blanking stops at the first nonzero digit, digit 0 always shows.
    always_comb begin
        num_enc = '1;
        lead    = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (BLANK_LZ && lead && (k != 0) && (bcd_q[4*k +: 4] == 4'd0)) begin
                num_enc[8*k +: 8] = 8'hFF;
            end else begin
                num_enc[8*k +: 8] = seg7(bcd_q[4*k +: 4]);
                lead              = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            num       <= '1;
            last_q    <= '0;
            pending_q <= 1'b1;
            cnt_q     <= '0;
            work_q    <= '0;
            bcd_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pending_q || (score != last_q)) begin
                        work_q    <= (score > ClampVal) ? ClampVal : score;
                        last_q    <= score;
                        pending_q <= 1'b0;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= StConv;
                        busy      <= 1'b1;
                    end
                end
                StConv: begin
                    {bcd_q, work_q} <= {bcd_adj, work_q} << 1;
                    cnt_q           <= cnt_q + 5'd1;
                    if (cnt_q == LastIter) begin
                        state_q <= StEnc;
                    end
                end
                StEnc: begin
                    num     <= num_enc;
                    done    <= 1'b1;
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
